marquee_lights_ctrl: RTL and testbench

//  Parametrised running-light controller for the board LED bar. A lit block of
//  n = min(len+1, LED_W) adjacent LEDs steps once per TICK_DIV clocks.

---
 rtl/marquee_lights_ctrl.sv | 156 +++++++++++++++
 tb/tb_marquee_lights_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/marquee_lights_ctrl.sv
// rtl/marquee_lights_ctrl.sv - running-light controller for the board LED bar
// A block of n lit LEDs steps every TICK_DIV clocks in rotate, bounce or hold mode.
module marquee_lights_ctrl #(
    parameter int LED_W    = 16,
    parameter int LEN_W    = 4,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             running
);

    localparam int PW = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int NW = $clog2(LED_W + 1);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [1:0] M_ROT_L  = 2'b00;
    localparam logic [1:0] M_ROT_R  = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;

    logic [1:0]       state;
    logic [NW-1:0]    n_r;
    logic [PW-1:0]    pos;
    logic             dir_up;
    logic [TW-1:0]    tick;
    logic [LEN_W-1:0] len_r;

    logic             sync1, sync2, sync3;
    logic             btn_rise;
    logic             tick_end;
    logic             len_changed;
    logic [NW-1:0]    n_calc;
    logic [NW-1:0]    lim;
    logic [PW-1:0]    pos_next;
    logic             dir_next;

    // Button is asynchronous: two flops to synchronise, a third for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign btn_rise    = sync2 & ~sync3;
    assign tick_end    = (tick == TW'(TICK_DIV - 1));
    assign len_changed = (len != len_r);
    assign lim         = NW'(LED_W) - n_r;

    always_comb begin
        if (int'(len) + 1 >= LED_W) n_calc = NW'(LED_W);
        else                        n_calc = NW'(int'(len) + 1);
    end

    always_comb begin
        pos_next = pos;
        dir_next = dir_up;
        case (mode)
            M_ROT_L:  pos_next = (pos == PW'(LED_W - 1)) ? '0 : pos + 1'b1;
            M_ROT_R:  pos_next = (pos == '0) ? PW'(LED_W - 1) : pos - 1'b1;
            M_BOUNCE: begin
                // Rotating can leave the block past the bounce limit; snap back first.
                if (NW'(pos) > lim) begin
                    pos_next = PW'(lim);
                    dir_next = 1'b0;
                end else if (lim == '0) begin
                    pos_next = pos;
                end else if (dir_up) begin
                    if (NW'(pos) == lim) begin
                        pos_next = pos - 1'b1;
                        dir_next = 1'b0;
                    end else begin
                        pos_next = pos + 1'b1;
                    end
                end else begin
                    if (pos == '0) begin
                        pos_next = pos + 1'b1;
                        dir_next = 1'b1;
                    end else begin
                        pos_next = pos - 1'b1;
                    end
                end
            end
            default:  pos_next = pos;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            n_r    <= NW'(1);
            pos    <= '0;
            dir_up <= 1'b1;
            tick   <= '0;
            len_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (btn_rise) state <= S_LOAD;
                end
                S_LOAD: begin
                    n_r    <= n_calc;
                    len_r  <= len;
                    pos    <= '0;
                    dir_up <= 1'b1;
                    tick   <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (len_changed) begin
                        state <= S_LOAD;
                    end else if (btn_rise) begin
                        state <= S_PAUSE;
                    end else if (tick_end) begin
                        tick   <= '0;
                        pos    <= pos_next;
                        dir_up <= dir_next;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (len_changed)   state <= S_LOAD;
                    else if (btn_rise) state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        led = '0;
        if (state != S_IDLE) begin
            for (int i = 0; i < LED_W; i++) begin
                led[i] = (((i - int'(pos) + LED_W) % LED_W) < int'(n_r));
            end
        end
    end

    assign running = (state == S_RUN);

endmodule

// File: tb/tb_marquee_lights_ctrl.sv
// tb/tb_marquee_lights_ctrl.sv - self-checking bench for marquee_lights_ctrl
module tb_marquee_lights_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button = 1'b0;
    logic [3:0] len = 4'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] led;
    logic       running;

    int n_vec = 0;
    int n_err = 0;

    marquee_lights_ctrl #(.LED_W(8), .LEN_W(4), .TICK_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .len     (len),
        .mode    (mode),
        .led     (led),
        .running (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] len;
        logic [1:0] mode;
        int         step;
        logic [7:0] led;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] led;
        logic       run;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    task automatic push_exp(input string name, input logic [7:0] e_led, input logic e_run);
        exp_t e;
        e.name = name;
        e.led  = e_led;
        e.run  = e_run;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expected entry for led=%b running=%b", led, running);
        end else begin
            e = sb.pop_front();
            if (led !== e.led || running !== e.run) begin
                n_err++;
                $display("FAIL %s: led=%b running=%b, expected led=%b running=%b",
                         e.name, led, running, e.led, e.run);
            end
        end
    endtask

    task automatic expect_now(input string name, input logic [7:0] e_led, input logic e_run);
        push_exp(name, e_led, e_run);
        pop_cmp();
    endtask

    // Resets, presses the button and returns at the first negedge with running=1.
    task automatic start_run(input logic [3:0] l, input logic [1:0] m, output bit ok);
        ok     = 1'b0;
        rst    = 1'b0;
        button = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        len  = l;
        mode = m;
        @(negedge clk);
        button = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (running === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        button = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL start_timeout: running=%b after 12 clk, expected 1", running);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        vecs[0]  = '{4'd2,  2'd0, 0,  8'b0000_0111};
        vecs[1]  = '{4'd2,  2'd0, 1,  8'b0000_1110};
        vecs[2]  = '{4'd2,  2'd0, 2,  8'b0001_1100};
        vecs[3]  = '{4'd2,  2'd0, 6,  8'b1100_0001};
        vecs[4]  = '{4'd2,  2'd0, 7,  8'b1000_0011};
        vecs[5]  = '{4'd2,  2'd0, 8,  8'b0000_0111};
        vecs[6]  = '{4'd2,  2'd1, 1,  8'b1000_0011};
        vecs[7]  = '{4'd2,  2'd1, 2,  8'b1100_0001};
        vecs[8]  = '{4'd2,  2'd2, 5,  8'b1110_0000};
        vecs[9]  = '{4'd2,  2'd2, 6,  8'b0111_0000};
        vecs[10] = '{4'd2,  2'd2, 10, 8'b0000_0111};
        vecs[11] = '{4'd7,  2'd0, 3,  8'b1111_1111};
        vecs[12] = '{4'd7,  2'd2, 2,  8'b1111_1111};
        vecs[13] = '{4'd2,  2'd3, 5,  8'b0000_0111};
        vecs[14] = '{4'd0,  2'd0, 9,  8'b0000_0010};
        vecs[15] = '{4'd3,  2'd1, 1,  8'b1000_0111};
        vecs[16] = '{4'd0,  2'd2, 8,  8'b0100_0000};
        vecs[17] = '{4'd15, 2'd1, 2,  8'b1111_1111};

        // Reset state, then IDLE stays dark with no button press.
        @(negedge clk);
        expect_now("reset_state", 8'h00, 1'b0);
        rst = 1'b1;
        len = 4'd2;
        repeat (4) @(negedge clk);
        expect_now("idle_dark", 8'h00, 1'b0);

        for (int i = 0; i < 18; i++) begin
            start_run(vecs[i].len, vecs[i].mode, ok);
            if (!ok) continue;
            repeat (4 * vecs[i].step) @(negedge clk);
            push_exp($sformatf("vec%0d_step_start", i), vecs[i].led, 1'b1);
            pop_cmp();
            repeat (3) @(negedge clk);
            push_exp($sformatf("vec%0d_step_end", i), vecs[i].led, 1'b1);
            pop_cmp();
        end

        // Pause at tick 2, hold 20 clk, resume: next step 2 clk later.
        start_run(4'd2, 2'd0, ok);
        if (ok) begin
            repeat (4) @(negedge clk);
            button = 1'b1;
            repeat (3) @(negedge clk);
            expect_now("pause_enter", 8'b0000_1110, 1'b0);
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (j == 0) button = 1'b0;
                expect_now($sformatf("pause_hold%0d", j), 8'b0000_1110, 1'b0);
            end
            button = 1'b1;
            repeat (2) @(negedge clk);
            expect_now("pause_rise_cycle", 8'b0000_1110, 1'b0);
            @(negedge clk);
            button = 1'b0;
            expect_now("resume0", 8'b0000_1110, 1'b1);
            @(negedge clk);
            expect_now("resume1", 8'b0000_1110, 1'b1);
            @(negedge clk);
            expect_now("resume_step", 8'b0001_1100, 1'b1);
        end

        // len change in PAUSE wins over a same-cycle button edge.
        start_run(4'd2, 2'd0, ok);
        if (ok) begin
            repeat (4) @(negedge clk);
            button = 1'b1;
            repeat (3) @(negedge clk);
            expect_now("pause2_enter", 8'b0000_1110, 1'b0);
            @(negedge clk);
            button = 1'b0;
            repeat (4) @(negedge clk);
            button = 1'b1;
            repeat (2) @(negedge clk);
            len = 4'd9;
            @(negedge clk);
            expect_now("len_reload", 8'b0000_1110, 1'b0);
            @(negedge clk);
            button = 1'b0;
            expect_now("len_run_full", 8'b1111_1111, 1'b1);
            repeat (4) @(negedge clk);
            expect_now("len_edge_discarded", 8'b1111_1111, 1'b1);
        end

        // Asynchronous reset mid-run, then restart.
        start_run(4'd2, 2'd0, ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            expect_now("before_async_rst", 8'b0000_1110, 1'b1);
            rst = 1'b0;
            #1;
            expect_now("async_rst", 8'h00, 1'b0);
        end
        start_run(4'd2, 2'd0, ok);
        if (ok) expect_now("restart", 8'b0000_0111, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
